// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned ADD3_THRESH = 5;

  // Decimal digits needed to show 2**width - 1 without overflow.
  function automatic int unsigned min_digits(input int unsigned width);
    longint unsigned maxv;
    int unsigned     n;
    maxv = (64'd1 << width) - 64'd1;
    n    = 0;
    do begin
      n++;
      maxv = maxv / 64'd10;
    end while (maxv != 64'd0);
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/ready request and done/result response bundle for bin2bcd_seq.
// Port neg exists only when BCD_SIGN_EN is defined.
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BCD_SIGN_EN
  logic                  neg;

  modport master (output start, bin_in, input ready, done, bcd_out, overflow, neg);
  modport slave  (input start, bin_in, output ready, done, bcd_out, overflow, neg);
`else
  modport master (output start, bin_in, input ready, done, bcd_out, overflow);
  modport slave  (input start, bin_in, output ready, done, bcd_out, overflow);
`endif
endinterface

// File: rtl/bcd_add3_adj.sv
// Single BCD digit pre-shift correction: add 3 when the digit is 5 or more.
module bcd_add3_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);
  // Input never exceeds 9 here, so the 4-bit sum cannot wrap.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= DIGIT_W'(ADD3_THRESH)) digit_out = digit_in + DIGIT_W'(3);
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define BCD_SIGN_EN to treat bin_in as two's complement and report neg.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);
  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_sh_q;
  logic [WIDTH-1:0]   bin_sh_q;
  logic               ovf_acc_q;
  logic               ready_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [WIDTH-1:0]   bin_nxt;
  logic               ovf_nxt;
  logic [WIDTH-1:0]   operand;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_add3_adj u_adj (
      .digit_in  (bcd_sh_q[d*DIGIT_W +: DIGIT_W]),
      .digit_out (bcd_adj[d*DIGIT_W +: DIGIT_W])
    );
  end

  // The bit leaving the top digit means the value no longer fits in DIGITS.
  assign bcd_nxt = {bcd_adj[BCD_W-2:0], bin_sh_q[WIDTH-1]};
  assign bin_nxt = {bin_sh_q[WIDTH-2:0], 1'b0};
  assign ovf_nxt = ovf_acc_q | bcd_adj[BCD_W-1];

`ifdef BCD_SIGN_EN
  logic neg_pend_q;
  logic neg_q;
  logic in_neg;

  // Negating the most-negative value wraps to itself, which is the correct
  // unsigned magnitude.
  assign in_neg  = bus.bin_in[WIDTH-1];
  assign operand = in_neg ? (~bus.bin_in + WIDTH'(1)) : bus.bin_in;
  assign bus.neg = neg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start) neg_pend_q <= in_neg;
      if (state_q == SHIFT && cnt_q == CNT_W'(1)) neg_q <= neg_pend_q;
    end
  end
`else
  assign operand = bus.bin_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bcd_sh_q  <= '0;
      bin_sh_q  <= '0;
      ovf_acc_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bin_sh_q  <= operand;
            bcd_sh_q  <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= CNT_W'(WIDTH);
            ready_q   <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sh_q  <= bcd_nxt;
          bin_sh_q  <= bin_nxt;
          ovf_acc_q <= ovf_nxt;
          cnt_q     <= cnt_q - CNT_W'(1);
          // Results are published straight from the final shift so they are
          // valid during the done cycle.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            bcd_q   <= bcd_nxt;
            ovf_q   <= ovf_nxt;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed table, hand sequences and random vectors
// against an arithmetic model, on an 8-bit and a 12-bit instance.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if8 ();
  bin2bcd_seq_if #(.WIDTH(12), .DIGITS(3)) if12 ();

  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  bin2bcd_seq #(.WIDTH(12), .DIGITS(3)) dut12 (.clk(clk), .rst(rst), .bus(if12.slave));

  int n_vec = 0;
  int n_bad = 0;

  bit          sel = 1'b0;
  logic        rdy_s, done_s, ovf_s, neg_s;
  logic [11:0] bcd_s;

  always_comb begin
    rdy_s  = sel ? if12.ready    : if8.ready;
    done_s = sel ? if12.done     : if8.done;
    ovf_s  = sel ? if12.overflow : if8.overflow;
    bcd_s  = sel ? if12.bcd_out  : if8.bcd_out;
`ifdef BCD_SIGN_EN
    neg_s  = sel ? if12.neg      : if8.neg;
`else
    neg_s  = 1'b0;
`endif
  end

  typedef struct {
    bit          w12;
    logic [31:0] bin;
    logic [11:0] bcd;
    logic        ovf;
    logic        neg;
    bit          glitch;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w12, input logic st, input logic [31:0] v);
    if (w12) begin
      if12.start  = st;
      if12.bin_in = v[11:0];
    end else begin
      if8.start   = st;
      if8.bin_in  = v[7:0];
    end
  endtask

  // Reference: plain decimal arithmetic on the (sign-stripped) magnitude.
  task automatic model(input bit w12, input logic [31:0] v, output logic [13:0] res);
    longint unsigned mag;
    int              w;
    logic            n;
    w   = w12 ? 12 : 8;
    n   = 1'b0;
    mag = longint'(v) & ((64'd1 << w) - 64'd1);
`ifdef BCD_SIGN_EN
    if (mag >= (64'd1 << (w - 1))) begin
      n   = 1'b1;
      mag = (64'd1 << w) - mag;
    end
`endif
    res[13] = n;
    res[12] = (mag >= 64'd1000);
    res[3:0]  = 4'(mag % 10);
    res[7:4]  = 4'((mag / 10) % 10);
    res[11:8] = 4'((mag / 100) % 10);
  endtask

  task automatic convert(input bit w12, input logic [31:0] v, input logic [13:0] exp,
                         input bit glitch, input string name);
    int cyc;
    sel = w12;
    cyc = 0;
    while (!rdy_s && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " ready-before"}, 32'(rdy_s), 32'd1);
    drive(w12, 1'b1, v);
    @(negedge clk);
    // Scramble bin_in after acceptance; it must be ignored.
    drive(w12, 1'b0, $urandom);
    chk({name, " ready-drop"}, 32'(rdy_s), 32'd0);
    cyc = 1;
    while (!done_s && cyc < 100) begin
      drive(w12, glitch && cyc == 3, glitch ? 32'd7 : $urandom);
      @(negedge clk);
      cyc++;
    end
    drive(w12, 1'b0, 32'd0);
    chk({name, " latency"}, 32'(cyc), w12 ? 32'd13 : 32'd9);
    chk({name, " result"}, {18'd0, neg_s, ovf_s, bcd_s}, {18'd0, exp});
    @(negedge clk);
    chk({name, " after-done"}, {17'd0, done_s, rdy_s, neg_s, ovf_s, bcd_s},
        {17'd0, 1'b0, 1'b1, exp});
  endtask

  vec_t        tbl[8];
  logic [13:0] exp;
  logic [31:0] rv;
  bit          rw;
  int          seen;

  initial begin
`ifdef BCD_SIGN_EN
    tbl[0] = '{1'b0, 32'h80,  12'h128, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 32'hFF,  12'h001, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'd127, 12'h127, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'd0,   12'h000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'hFFF, 12'h001, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 32'd999, 12'h999, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 32'h800, 12'h048, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 32'd99,  12'h099, 1'b0, 1'b0, 1'b0};
`else
    tbl[0] = '{1'b0, 32'd255,  12'h255, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'd0,    12'h000, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'd99,   12'h099, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'd128,  12'h128, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'd4095, 12'h095, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'd999,  12'h999, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 32'd1000, 12'h000, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 32'd1,    12'h001, 1'b0, 1'b0, 1'b0};
`endif
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    sel = 1'b0;
    chk("reset8", {18'd0, rdy_s, done_s, ovf_s, bcd_s}, {18'd0, 1'b1, 1'b0, 1'b0, 12'h0});
    sel = 1'b1;
    chk("reset12", {18'd0, rdy_s, done_s, ovf_s, bcd_s}, {18'd0, 1'b1, 1'b0, 1'b0, 12'h0});
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      convert(tbl[i].w12, tbl[i].bin, {tbl[i].neg, tbl[i].ovf, tbl[i].bcd}, tbl[i].glitch,
              $sformatf("tbl%0d", i));
    end

    // Single done despite a start pulse during SHIFT.
    sel = 1'b0;
    seen = 0;
    drive(1'b0, 1'b1, 32'd128);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, c == 2, 32'd7);
      if (done_s) seen++;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'd0);
    chk("single-done", 32'(seen), 32'd1);
`ifndef BCD_SIGN_EN
    chk("single-done value", 32'(bcd_s), 32'h128);
`endif

    // Asynchronous reset part-way through a conversion of 200.
    drive(1'b0, 1'b1, 32'd200);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid-reset", {18'd0, rdy_s, done_s, ovf_s, bcd_s}, {18'd0, 1'b1, 1'b0, 1'b0, 12'h0});
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_s) seen++;
    end
    chk("no-done-after-reset", 32'(seen), 32'd0);
    model(1'b0, 32'd42, exp);
    convert(1'b0, 32'd42, exp, 1'b0, "post-reset42");

    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      rv = $urandom;
      model(rw, rv, exp);
      convert(rw, rv, exp, $urandom_range(0, 3) == 0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one iteration per clock.
Accepts a WIDTH-bit binary word on a start/ready handshake and returns DIGITS packed BCD digits with a one-cycle done pulse.
Sits between arithmetic/counter datapaths and seven-segment or display drivers; supersedes the fixed 8-bit, 3-digit converter.

Parameters:
WIDTH, 8, binary input width in bits (legal range 2..32)
DIGITS, 3, number of BCD output digits; full range needs DIGITS >= ceil(WIDTH*0.30103), otherwise overflow reporting applies

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request conversion of bin_in; sampled only when ready=1
bin_in  input  WIDTH  binary operand, captured on accepted start
ready  output  1  block idle, start will be accepted
done  output  1  single-cycle pulse, bcd_out/overflow valid from this cycle
bcd_out  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0]
overflow  output  1  result exceeded DIGITS digits; bcd_out holds value modulo 10^DIGITS

Behaviour:
- Reset (rst=0, asynchronous, active-low; clock clk): state IDLE, ready=1, done=0, bcd_out=0, overflow=0, iteration counter=0, shift register cleared.
- Reset asserted mid-conversion aborts immediately; no done pulse; outputs return to reset values.
- State machine IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: ready=1. On start=1, capture bin_in into binary field, clear BCD field and overflow accumulator, counter=WIDTH, go to SHIFT; ready drops the next cycle.
- SHIFT: each cycle, every BCD digit >= 5 gets +3 (all digits corrected in parallel, combinational), then the whole {BCD,binary} register shifts left by 1; the bit shifted out of the top digit is ORed into the overflow accumulator. Counter decrements; when it reaches 1 the last shift occurs and next state is DONE.
- DONE: bcd_out <= BCD field, overflow <= accumulator, done=1 for exactly this cycle, ready=0; next state IDLE.
- Latency: accepted start at edge N -> done high in cycle N+WIDTH+1; next start accepted at edge N+WIDTH+2.
- start while ready=0 is ignored (not queued); bin_in changes after acceptance have no effect.
- bcd_out/overflow hold their last values until the next done; they never show intermediate shift values.
- Per-digit add-3 is 4-bit, no carry between digits (the value never exceeds 12 before the shift).
- Input 0 yields all-zero digits, overflow=0.

Optional Feature:
BCD_SIGN_EN: when defined, bin_in is two's complement; magnitude |bin_in| is converted (most-negative value converts correctly using a WIDTH-bit unsigned magnitude) and an extra output neg (1 bit) is registered with done, reset 0, 1 when bin_in was negative. When not defined, bin_in is unsigned and port neg does not exist.

Decomposition:
- Package bin2bcd_pkg: state enum typedef (IDLE, SHIFT, DONE), DIGIT_W=4 constant, ADD3_THRESH=5 constant, function min_digits(width) for elaboration-time checks (assertion if DIGITS < min_digits(WIDTH) without intent is a warning only).
- Sub-module bcd_add3_adj: combinational single-digit correction (in >= 5 ? in+3 : in), generated DIGITS times.

Test Plan:
- WIDTH=8, DIGITS=3, start with bin_in=255 -> done 9 cycles later, bcd_out=12'h255, overflow=0, ready back 1 cycle after done.
- bin_in=0, then bin_in=8'd99 back-to-back at earliest ready -> bcd_out=12'h000 then 12'h099, two distinct done pulses.
- start pulsed again during SHIFT with bin_in=7 after accepted bin_in=128 -> single done, bcd_out=12'h128.
- rst driven low at iteration 4 of a conversion of 200 -> outputs 0 immediately, no done; new start with 42 -> bcd_out=12'h042.
- WIDTH=12, DIGITS=3, bin_in=4095 -> bcd_out=12'h095, overflow=1; bin_in=999 -> 12'h999, overflow=0.
- BCD_SIGN_EN, WIDTH=8: bin_in=8'h80 -> bcd_out=12'h128, neg=1; bin_in=8'hFF -> 12'h001, neg=1; bin_in=8'd127 -> 12'h127, neg=0.
